// File: rtl/icache_line_param.sv
`default_nettype none
// ============================================================================
// Module   : icache_line_param
// Purpose  : Direct-mapped, read-only instruction cache. The line size is
//            1/2/4/8 words and the depth is set by INDEX_BITS. A miss starts
//            a line-aligned burst refill of 16-bit halfwords. A flush
//            invalidates every line, one index per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module icache_line_param #(
  parameter int LINE_WORDS = 4,
  parameter int INDEX_BITS = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  DStrobe,
  input  logic [ADDR_WIDTH-1:0] DAddress,
  output logic [31:0]           DData,
  output logic                  DReady,
  input  logic                  Flush,
  output logic                  FlushDone,
  output logic                  Miss,
  output logic                  MStrobe,
  input  logic                  MGrant,
  output logic [ADDR_WIDTH-1:0] MAddress,
  input  logic                  MValid,
  input  logic [15:0]           MData
);

  localparam int C_OFF_BITS   = $clog2(LINE_WORDS);
  localparam int C_TAG_BITS   = ADDR_WIDTH - INDEX_BITS - C_OFF_BITS - 2;
  localparam int C_NUM_LINES  = 1 << INDEX_BITS;
  localparam int C_WADDR_BITS = INDEX_BITS + C_OFF_BITS;
  localparam int C_BEAT_BITS  = C_OFF_BITS + 1;

  localparam logic [C_BEAT_BITS-1:0]  C_LAST_BEAT      = C_BEAT_BITS'(2 * LINE_WORDS - 1);
  localparam logic [INDEX_BITS-1:0]   C_LAST_INDEX     = INDEX_BITS'(C_NUM_LINES - 1);
  localparam logic [ADDR_WIDTH-1:0]   C_HW_LINE_MASK   = ~ADDR_WIDTH'(2 * LINE_WORDS - 1);
  localparam logic [C_WADDR_BITS-1:0] C_WORD_LINE_MASK = ~C_WADDR_BITS'(LINE_WORDS - 1);

  // Reject unsupported line sizes at elaboration.
  generate
    if (!(LINE_WORDS == 1 || LINE_WORDS == 2 || LINE_WORDS == 4 || LINE_WORDS == 8)) begin : g_bad_line_words
      $error("icache_line_param: LINE_WORDS must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_REQ    = 3'd2,
    S_FILL   = 3'd3,
    S_UPDATE = 3'd4,
    S_FLUSH  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  // Storage: valid bits are flops (they need reset/flush), tags and data are RAMs.
  logic [C_NUM_LINES-1:0] r_valid;
  logic [C_TAG_BITS-1:0]  r_tag_ram  [C_NUM_LINES];
  logic [31:0]            r_data_ram [C_NUM_LINES * LINE_WORDS];
  logic [C_TAG_BITS-1:0]  r_tag_rd;
  logic [31:0]            r_data_rd;

  // Refill context captured when the miss is detected.
  logic [INDEX_BITS-1:0]   r_fill_index;
  logic [C_TAG_BITS-1:0]   r_fill_tag;
  logic [C_WADDR_BITS-1:0] r_fill_base;
  logic [ADDR_WIDTH-1:0]   r_maddr;
  logic [C_BEAT_BITS-1:0]  r_beat;
  logic [15:0]             r_lo;

  // Flush bookkeeping.
  logic                  r_flush_pend;
  logic [INDEX_BITS-1:0] r_fcnt;
  logic                  r_fdone;

  logic [C_WADDR_BITS-1:0] w_rd_waddr;
  logic [C_WADDR_BITS-1:0] w_wr_waddr;
  logic [INDEX_BITS-1:0]   w_index;
  logic [C_TAG_BITS-1:0]   w_tag;
  logic                    w_hit;
  logic                    w_lookup_miss;
  logic                    w_beat_last;
  logic                    w_word_we;
  logic                    w_tag_we;

  // The word address {index, offset} is simply DAddress with the byte bits dropped.
  assign w_rd_waddr    = C_WADDR_BITS'(DAddress >> 2);
  assign w_index       = INDEX_BITS'(DAddress >> (C_OFF_BITS + 2));
  assign w_tag         = C_TAG_BITS'(DAddress >> (C_OFF_BITS + 2 + INDEX_BITS));
  assign w_hit         = r_valid[w_index] && (r_tag_rd == w_tag);
  assign w_lookup_miss = (r_state == S_LOOKUP) && DStrobe && !w_hit;
  assign w_beat_last   = MValid && (r_beat == C_LAST_BEAT);
  assign w_word_we     = (r_state == S_FILL) && MValid && r_beat[0];
  assign w_wr_waddr    = r_fill_base | C_WADDR_BITS'(r_beat >> 1);
  assign w_tag_we      = (r_state == S_UPDATE);

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and output decode.
  always_comb begin
    w_next    = r_state;
    DReady    = 1'b0;
    DData     = '0;
    Miss      = 1'b0;
    MStrobe   = 1'b0;
    MAddress  = '0;
    FlushDone = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Flush || r_flush_pend) w_next = S_FLUSH;
        else if (DStrobe)          w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        // A request dropped while refilling ends here silently.
        if (w_lookup_miss) begin
          Miss   = 1'b1;
          w_next = S_REQ;
        end else begin
          DReady = DStrobe;
          DData  = DStrobe ? r_data_rd : '0;
          w_next = S_IDLE;
        end
      end
      S_REQ: begin
        Miss     = 1'b1;
        MStrobe  = 1'b1;
        MAddress = r_maddr;
        if (MGrant) w_next = S_FILL;
      end
      S_FILL: begin
        Miss     = 1'b1;
        MAddress = r_maddr;
        if (w_beat_last) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        w_next = S_LOOKUP;
      end
      S_FLUSH: begin
        FlushDone = r_fdone;
        if (r_fdone) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Capture refill context on a miss and count/assemble refill beats.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_fill_index <= '0;
      r_fill_tag   <= '0;
      r_fill_base  <= '0;
      r_maddr      <= '0;
      r_beat       <= '0;
      r_lo         <= '0;
    end else begin
      if (w_lookup_miss) begin
        r_fill_index <= w_index;
        r_fill_tag   <= w_tag;
        r_fill_base  <= w_rd_waddr & C_WORD_LINE_MASK;
        r_maddr      <= (DAddress >> 1) & C_HW_LINE_MASK;
      end
      if (r_state == S_REQ) begin
        r_beat <= '0;
      end else if ((r_state == S_FILL) && MValid) begin
        r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
        if (!r_beat[0]) r_lo <= MData;
      end
    end
  end

  // Flush request latching and the one-index-per-cycle sweep.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_flush_pend <= 1'b0;
      r_fcnt       <= '0;
      r_fdone      <= 1'b0;
    end else begin
      // IDLE always services a pending flush, so it can be dropped there.
      if (r_state == S_IDLE) r_flush_pend <= 1'b0;
      else if (Flush)        r_flush_pend <= 1'b1;

      if (r_state != S_FLUSH) begin
        r_fcnt  <= '0;
        r_fdone <= 1'b0;
      end else if (!r_fdone) begin
        if (r_fcnt == C_LAST_INDEX) r_fdone <= 1'b1;
        else                        r_fcnt  <= r_fcnt + 1'b1;
      end
    end
  end

  // Valid bits: set on line install, cleared by the flush sweep.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_valid <= '0;
    end else if (r_state == S_UPDATE) begin
      r_valid[r_fill_index] <= 1'b1;
    end else if ((r_state == S_FLUSH) && !r_fdone) begin
      r_valid[r_fcnt] <= 1'b0;
    end
  end

  // Tag/data RAMs with one-cycle synchronous read; the tag written in UPDATE
  // is forwarded so the re-lookup that follows sees the new line.
  always_ff @(posedge Clk) begin
    if (w_word_we) r_data_ram[w_wr_waddr] <= {MData, r_lo};
    if (w_tag_we)  r_tag_ram[r_fill_index] <= r_fill_tag;
    r_data_rd <= r_data_ram[w_rd_waddr];
    r_tag_rd  <= (w_tag_we && (r_fill_index == w_index)) ? r_fill_tag : r_tag_ram[w_index];
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_line_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_line_param
// Purpose  : Directed self-checking bench for icache_line_param
//            (LINE_WORDS=4, INDEX_BITS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_line_param;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        DStrobe;
  logic [31:0] DAddress;
  logic [31:0] DData;
  logic        DReady;
  logic        Flush;
  logic        FlushDone;
  logic        Miss;
  logic        MStrobe;
  logic        MGrant;
  logic [31:0] MAddress;
  logic        MValid;
  logic [15:0] MData;

  int n_checks = 0;
  int n_fail   = 0;

  icache_line_param #(
    .LINE_WORDS(4),
    .INDEX_BITS(4),
    .ADDR_WIDTH(32)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .DStrobe  (DStrobe),
    .DAddress (DAddress),
    .DData    (DData),
    .DReady   (DReady),
    .Flush    (Flush),
    .FlushDone(FlushDone),
    .Miss     (Miss),
    .MStrobe  (MStrobe),
    .MGrant   (MGrant),
    .MAddress (MAddress),
    .MValid   (MValid),
    .MData    (MData)
  );

  always #5 Clk = ~Clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Line word at offset off, built from beats base, base+step, base+2*step, ...
  function automatic logic [31:0] line_word(input logic [15:0] base, input logic [15:0] step, input int off);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = base + 16'(2 * off) * step;
    hi = lo + step;
    return {hi, lo};
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_dready"},    32'(DReady),    32'd0);
    check_eq({tag, "_flushdone"}, 32'(FlushDone), 32'd0);
    check_eq({tag, "_miss"},      32'(Miss),      32'd0);
    check_eq({tag, "_mstrobe"},   32'(MStrobe),   32'd0);
    check_eq({tag, "_maddress"},  MAddress,       32'd0);
    check_eq({tag, "_ddata"},     DData,          32'd0);
  endtask

  // Starts at the negedge before the LOOKUP cycle of a request already presented.
  task automatic refill(input logic [31:0] exp_maddr, input logic [15:0] base, input logic [15:0] step,
                        input int gd, input int gap, input logic [31:0] exp_word,
                        input int abort_at, input int flush_at);
    bit aborted;
    aborted = 1'b0;
    @(negedge Clk);
    check_eq("lookup_miss", 32'(Miss), 32'd1);
    check_eq("lookup_noready", 32'(DReady), 32'd0);
    @(negedge Clk);
    check_eq("req_mstrobe", 32'(MStrobe), 32'd1);
    check_eq("req_maddress", MAddress, exp_maddr);
    for (int i = 0; i < gd; i++) begin
      @(negedge Clk);
      check_eq("req_hold_mstrobe", 32'(MStrobe), 32'd1);
      check_eq("req_hold_maddress", MAddress, exp_maddr);
    end
    MGrant = 1'b1;
    @(negedge Clk);
    MGrant = 1'b0;
    check_eq("fill_mstrobe_low", 32'(MStrobe), 32'd0);
    for (int b = 0; b < 8; b++) begin
      if (b == abort_at) begin
        Reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge Clk);
        Reset   = 1'b0;
        DStrobe = 1'b0;
        for (int s = b; s < 8; s++) begin
          MValid = 1'b1;
          MData  = 16'hDEAD;
          @(negedge Clk);
        end
        MValid = 1'b0;
        check_eq("post_rst_miss", 32'(Miss), 32'd0);
        check_eq("post_rst_ready", 32'(DReady), 32'd0);
        aborted = 1'b1;
        break;
      end
      MValid = 1'b1;
      MData  = base + 16'(b) * step;
      Flush  = (b == flush_at);
      @(negedge Clk);
      MValid = 1'b0;
      Flush  = 1'b0;
      if (b < 7) begin
        check_eq("fill_miss_high", 32'(Miss), 32'd1);
        repeat (gap) @(negedge Clk);
      end
    end
    if (!aborted) begin
      check_eq("update_miss_low", 32'(Miss), 32'd0);
      check_eq("update_noready", 32'(DReady), 32'd0);
      @(negedge Clk);
      check_eq("refetch_dready", 32'(DReady), 32'd1);
      check_eq("refetch_ddata", DData, exp_word);
      DStrobe = 1'b0;
    end
  endtask

  task automatic read_miss(input logic [31:0] addr, input logic [31:0] exp_maddr,
                           input logic [15:0] base, input logic [15:0] step,
                           input int gd, input int gap, input int abort_at, input int flush_at);
    @(negedge Clk);
    DStrobe  = 1'b1;
    DAddress = addr;
    refill(exp_maddr, base, step, gd, gap, line_word(base, step, int'((addr >> 2) & 32'd3)),
           abort_at, flush_at);
  endtask

  task automatic read_hit(input logic [31:0] addr, input logic [31:0] exp_word, input string tag);
    @(negedge Clk);
    DStrobe  = 1'b1;
    DAddress = addr;
    @(negedge Clk);
    check_eq({tag, "_dready"}, 32'(DReady), 32'd1);
    check_eq({tag, "_ddata"}, DData, exp_word);
    check_eq({tag, "_nomiss"}, 32'(Miss), 32'd0);
    DStrobe = 1'b0;
  endtask

  // Counts negedges until FlushDone, then checks it is a single-cycle pulse.
  task automatic wait_flush_done(input int exp_cycles, input string tag);
    int k;
    bit seen_ready;
    k = 0;
    seen_ready = 1'b0;
    do begin
      @(negedge Clk);
      Flush = 1'b0;
      k++;
      if (DReady) seen_ready = 1'b1;
    end while (!FlushDone && k < 60);
    check_eq({tag, "_cycles"}, 32'(k), 32'(exp_cycles));
    check_eq({tag, "_noready"}, 32'(seen_ready), 32'd0);
    @(negedge Clk);
    check_eq({tag, "_pulse"}, 32'(FlushDone), 32'd0);
  endtask

  initial begin
    Reset    = 1'b1;
    DStrobe  = 1'b0;
    DAddress = '0;
    Flush    = 1'b0;
    MGrant   = 1'b0;
    MValid   = 1'b0;
    MData    = '0;
    repeat (2) @(negedge Clk);
    check_all_zero("reset");
    Reset = 1'b0;

    // 1: cold miss then hits in the same line
    read_miss(32'h100, 32'h80, 16'h1111, 16'h1111, 0, 0, -1, -1);
    read_hit(32'h10C, 32'h8888_7777, "t1_hit_10c");
    read_hit(32'h104, 32'h4444_3333, "t1_hit_104");

    // 2: conflicting tag on index 0 evicts, original misses again
    read_miss(32'h500, 32'h280, 16'h5000, 16'h0001, 0, 0, -1, -1);
    read_miss(32'h100, 32'h80, 16'h1111, 16'h1111, 0, 0, -1, -1);

    // 3: delayed grant and gapped beats
    read_miss(32'h908, 32'h480, 16'h3000, 16'h0001, 5, 2, -1, -1);
    read_hit(32'h904, 32'h3003_3002, "t3_hit_904");

    // 4: three lines resident, flush, everything misses afterwards
    read_miss(32'h210, 32'h108, 16'h4000, 16'h0001, 0, 0, -1, -1);
    read_miss(32'h320, 32'h190, 16'h6000, 16'h0001, 0, 0, -1, -1);
    read_hit(32'h90C, 32'h3007_3006, "t4_hit_90c");
    @(negedge Clk);
    Flush = 1'b1;
    wait_flush_done(17, "t4_flush");
    read_miss(32'h908, 32'h480, 16'h3000, 16'h0001, 0, 0, -1, -1);
    read_miss(32'h210, 32'h108, 16'h4000, 16'h0001, 0, 0, -1, -1);

    // 5: reset in the middle of a refill
    read_miss(32'h100, 32'h80, 16'h7000, 16'h0001, 0, 0, 4, -1);
    read_miss(32'h210, 32'h108, 16'h4000, 16'h0001, 0, 0, -1, -1);
    read_miss(32'h100, 32'h80, 16'h1111, 16'h1111, 0, 0, -1, -1);

    // 6a: flush and fetch in the same idle cycle; flush goes first
    @(negedge Clk);
    Flush    = 1'b1;
    DStrobe  = 1'b1;
    DAddress = 32'h100;
    wait_flush_done(17, "t6_flush_first");
    refill(32'h80, 16'hC000, 16'h0001, 0, 0, 32'hC001_C000, -1, -1);

    // 6b: flush during FILL is deferred until after UPDATE + LOOKUP
    read_miss(32'h324, 32'h190, 16'hD000, 16'h0001, 1, 1, -1, 3);
    wait_flush_done(18, "t6_flush_deferred");
    read_miss(32'h324, 32'h190, 16'hD000, 16'h0001, 0, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
